// File: rtl/uart_rx_string.sv
// Line assembler behind uart_frame_rx: collects bytes into a packed
// string ended by a terminator, an idle timeout, overflow or framing error.
module uart_rx_string #(
  parameter int         SYS_FREQ   = 125,
  parameter int         MAX_LEN    = 32,
  parameter logic [7:0] TERM_CHAR  = 8'h0D,
  parameter bit         IGNORE_LF  = 1'b1,
  parameter int         TIMEOUT_US = 2000
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         rx_err,
  output logic [255:0] string_out,
  output logic [5:0]   string_len,
  output logic         str_valid,
  output logic         timed_out,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  localparam int          TCYC  = SYS_FREQ * TIMEOUT_US;
  localparam logic [31:0] TLAST = (TCYC > 0) ? 32'(TCYC - 1) : 32'd0;
  localparam logic [5:0]  MAXL  = 6'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t         state_q, state_d;
  logic [255:0]   shreg_q, shreg_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [31:0]    timer_q, timer_d;
  logic [255:0]   str_q, str_d;
  logic [5:0]     len_q, len_d;
  logic           sv_q, sv_d;
  logic           to_q, to_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic is_lf, is_term, tmo;

  assign is_lf   = IGNORE_LF && (rx_data == 8'h0A);
  assign is_term = (rx_data == TERM_CHAR);
  assign tmo     = (TCYC != 0) && (timer_q == TLAST);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    timer_d = (state_q == IDLE) ? 32'd0 : timer_q + 32'd1;
    str_d   = str_q;
    len_d   = len_q;
    to_d    = to_q;
    sv_d    = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    if (rx_err) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else if (rx_valid) begin
      timer_d = '0;
      if (!is_lf) begin
        unique case (state_q)
          IDLE: if (!is_term) begin
            shreg_d = {248'b0, rx_data};
            cnt_d   = 6'd1;
            state_d = COLLECT;
          end
          COLLECT: if (is_term) begin
            str_d   = shreg_q;
            len_d   = cnt_q;
            to_d    = 1'b0;
            sv_d    = 1'b1;
            state_d = IDLE;
          end else if (cnt_q < MAXL) begin
            shreg_d = {shreg_q[247:0], rx_data};
            cnt_d   = cnt_q + 6'd1;
          end else begin
            state_d = DISCARD;
          end
          DISCARD: if (is_term) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (tmo) begin
      unique case (state_q)
        COLLECT: begin
          str_d   = shreg_q;
          len_d   = cnt_q;
          to_d    = 1'b1;
          sv_d    = 1'b1;
          state_d = IDLE;
        end
        DISCARD: begin
          ovf_d   = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      str_q   <= '0;
      len_q   <= '0;
      sv_q    <= 1'b0;
      to_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      str_q   <= str_d;
      len_q   <= len_d;
      sv_q    <= sv_d;
      to_q    <= to_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign string_out = str_q;
  assign string_len = len_q;
  assign str_valid  = sv_q;
  assign timed_out  = to_q;
  assign ovf        = ovf_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_string.sv
// Bench for uart_rx_string: directed and random lines checked against
// a queue-based line model; short timeout for simulation speed.
`timescale 1ns/1ps
module tb_uart_rx_string;

  logic         clk = 1'b0;
  logic         reset_p = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_err = 1'b0;
  logic [255:0] string_out;
  logic [5:0]   string_len;
  logic         str_valid, timed_out, ovf, err, busy;

  uart_rx_string #(.TIMEOUT_US(2)) dut (
    .clk(clk), .reset_p(reset_p), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_err(rx_err), .string_out(string_out),
    .string_len(string_len), .str_valid(str_valid),
    .timed_out(timed_out), .ovf(ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] s;
    logic [5:0]   n;
    logic         to;
  } line_t;

  line_t      got_q[$];
  line_t      exp_q[$];
  int         got_ovf = 0, got_err = 0, exp_ovf = 0, exp_err = 0;
  time        t_last = 0, sv_t = 0;
  int         n_checks = 0, n_fail = 0;

  logic [7:0] m_line[$];
  bit         m_disc = 0;

  localparam logic [255:0] L32 = "ABCDEFGHIJKLMNOPQRSTUVWXYZ789012";

  always @(negedge clk) begin
    if (str_valid) begin
      got_q.push_back('{string_out, string_len, timed_out});
      sv_t = $time;
    end
    if (ovf) got_ovf++;
    if (err) got_err++;
  end

  function automatic line_t pack(input bit to);
    line_t r;
    int n;
    n = m_line.size();
    r.s = '0;
    r.n = 6'(n);
    r.to = to;
    for (int k = 0; k < n; k++) r.s[8*(n-1-k) +: 8] = m_line[k];
    return r;
  endfunction

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'h0A) return;
    if (m_disc) begin
      if (b == 8'h0D) begin m_disc = 0; exp_ovf++; end
      return;
    end
    if (b == 8'h0D) begin
      if (m_line.size() > 0) begin
        exp_q.push_back(pack(1'b0));
        m_line.delete();
      end
      return;
    end
    if (m_line.size() == 32) begin
      m_disc = 1;
      m_line.delete();
      return;
    end
    m_line.push_back(b);
  endtask

  task automatic m_timeout();
    if (m_disc) begin m_disc = 0; exp_ovf++; end
    else if (m_line.size() > 0) begin
      exp_q.push_back(pack(1'b1));
      m_line.delete();
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    t_last = $time;
    #1 rx_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    m_byte(b);
    send(b);
  endtask

  task automatic feed_str(input string s);
    for (int i = 0; i < s.len(); i++) feed(s[i]);
  endtask

  task automatic pulse_err();
    @(negedge clk);
    rx_err = 1'b1;
    @(posedge clk);
    #1 rx_err = 1'b0;
    exp_err++;
    m_disc = 0;
    m_line.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_p = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_p = 1'b0;
    m_disc = 0;
    m_line.delete();
  endtask

  task automatic check_results(input string tag);
    repeat (5) @(negedge clk);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s line_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].n !== exp_q[i].n || got_q[i].s !== exp_q[i].s ||
          got_q[i].to !== exp_q[i].to) begin
        n_fail++;
        $display("FAIL %s line%0d got len=%0d to=%b s=%h exp len=%0d to=%b s=%h",
                 tag, i, got_q[i].n, got_q[i].to, got_q[i].s,
                 exp_q[i].n, exp_q[i].to, exp_q[i].s);
      end
    end
    n_checks++;
    if (got_ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s ovf_count got=%0d exp=%0d", tag, got_ovf, exp_ovf);
    end
    n_checks++;
    if (got_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s err_count got=%0d exp=%0d", tag, got_err, exp_err);
    end
    got_q.delete();
    exp_q.delete();
    got_ovf = 0; got_err = 0; exp_ovf = 0; exp_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (string_out !== '0 || string_len !== '0 || str_valid !== 1'b0 ||
        timed_out !== 1'b0 || ovf !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got len=%0d sv=%b to=%b ovf=%b err=%b busy=%b exp all 0",
               string_len, str_valid, timed_out, ovf, err, busy);
    end
  endtask

  task automatic test_on();
    feed("O");
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_collect got=%b exp=1", busy);
    end
    feed("N");
    feed(8'h0D);
    n_checks++;
    if (str_valid !== 1'b1 || string_out[15:0] !== 16'h4F4E ||
        string_out[255:16] !== '0 || string_len !== 6'd2 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL on_latency got sv=%b s=%h len=%0d to=%b exp sv=1 s=4f4e len=2 to=0",
               str_valid, string_out[15:0], string_len, timed_out);
    end
    check_results("on");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_crlf();
    feed_str("AB");
    feed(8'h0D); feed(8'h0A);
    feed("C");
    feed(8'h0D);
    check_results("crlf");
  endtask

  task automatic test_maxlen();
    feed_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ789012");
    feed(8'h0D);
    repeat (2) @(negedge clk);
    n_checks++;
    if (string_out !== L32 || string_len !== 6'd32) begin
      n_fail++;
      $display("FAIL len32 got len=%0d s=%h exp len=32 s=%h", string_len, string_out, L32);
    end
    feed_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ7890123");
    feed(8'h0D);
    repeat (2) @(negedge clk);
    n_checks++;
    if (string_out !== L32 || string_len !== 6'd32) begin
      n_fail++;
      $display("FAIL ovf_hold got len=%0d s=%h exp len=32 s=%h", string_len, string_out, L32);
    end
    check_results("maxlen");
  endtask

  task automatic test_timeout();
    int lat;
    feed_str("12");
    for (int i = 0; i < 400 && got_q.size() == 0; i++) @(negedge clk);
    n_checks++;
    if (got_q.size() == 0) begin
      n_fail++;
      $display("FAIL timeout_wait got=no str_valid exp=str_valid within 400 cycles");
    end else begin
      lat = int'((sv_t - 5 - t_last) / 10);
      if (lat !== 250) begin
        n_fail++;
        $display("FAIL timeout_latency got=%0d exp=250", lat);
      end
    end
    m_timeout();
    check_results("timeout");
    for (int i = 0; i < 33; i++) feed("A");
    repeat (300) @(negedge clk);
    m_timeout();
    check_results("timeout_ovf");
  endtask

  task automatic test_err_reset();
    feed_str("XY");
    pulse_err();
    feed("Z");
    feed(8'h0D);
    pulse_err();
    check_results("err");
    feed_str("QQ");
    do_reset();
    feed("R");
    feed(8'h0D);
    check_results("reset_mid");
  endtask

  task automatic test_random();
    int len;
    for (int b = 0; b < 6; b++) begin
      for (int l = 0; l < 6; l++) begin
        len = $urandom_range(0, 36);
        if ($urandom_range(0, 3) == 0) len = 32;
        for (int i = 0; i < len; i++) begin
          feed(8'($urandom_range(8'h20, 8'h7E)));
          if ($urandom_range(0, 7) == 0) feed(8'h0A);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        feed(8'h0D);
        if ($urandom_range(0, 1) == 0) feed(8'h0A);
      end
      check_results("random");
    end
  endtask

  initial begin
    test_reset();
    test_on();
    test_crlf();
    test_maxlen();
    test_timeout();
    test_err_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
